serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// through a single full-subtractor stage and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bw_q, bw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bw_next;

    // Full-subtractor stage on the current LSBs of the operand shift registers
    always_comb begin
        a_bit   = a_q[0];
        b_bit   = b_q[0];
        d_bit   = a_bit ^ b_bit ^ bw_q;
        bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        bw_d         = bw_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    bw_d    = borrow_in;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                bw_d  = bw_next;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                // Results are published only on the MSB step so they stay stable until the next one
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d      = S_DONE;
                    diff_d       = {d_bit, res_q[WIDTH-1:1]};
                    borrow_out_d = bw_next;
                    overflow_d   = bw_q ^ bw_next;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            res_q        <= {WIDTH{1'b0}};
            bw_q         <= 1'b0;
            diff_q       <= {WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            bw_q         <= bw_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected results and
// done-cycle, checked by a monitor whenever done pulses.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
        int unsigned  cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bin, input int unsigned dcyc);
        exp_t       e;
        logic [W:0] r;
        int         sx, sy, s;
        r      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
        e.diff = r[W-1:0];
        e.bo   = r[W];
        sx     = $signed(x);
        sy     = $signed(y);
        s      = sx - sy - int'(bin);
        e.ov   = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        e.cyc  = dcyc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("diff", {24'd0, diff}, {24'd0, e.diff});
                chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge: present operands with start high, queue the expectation
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
        start     = 1'b1;
        a         = x;
        b         = y;
        borrow_in = bin;
        last_exp  = model(x, y, bin, cyc + 1 + W);
        sb.push_back(last_exp);
    endtask

    // Called at a negedge: bounded wait for done, then check the hold-after-done behaviour
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < W + 4) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({tag, "_timeout"}, {31'd0, done}, 32'd1);
        end else begin
            chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
            chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
            chk({tag, "_diff_held"}, {24'd0, diff}, {24'd0, last_exp.diff});
            chk({tag, "_bo_held"}, {31'd0, borrow_out}, {31'd0, last_exp.bo});
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bin);
        launch(x, y, bin);
        @(negedge clk);
        start     = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
        chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        wait_done(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_diff"}, {24'd0, diff}, 32'd0);
        chk({tag, "_bo"}, {31'd0, borrow_out}, 32'd0);
        chk({tag, "_ov"}, {31'd0, overflow}, 32'd0);
    endtask

    logic [W-1:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    initial begin
        int unsigned c0;
        reset     = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        #1;
        chk_zero("reset_async");
        repeat (2) @(negedge clk);
        chk_zero("reset_held");

        // First start accepted on the first edge after reset release
        reset = 1'b0;
        do_op("basic", 8'h05, 8'h03, 1'b0);
        do_op("neg", 8'h00, 8'h01, 1'b0);
        do_op("ovf", 8'h80, 8'h01, 1'b0);
        do_op("bin", 8'h10, 8'h0F, 1'b1);

        // start during RUN is ignored
        launch(8'h37, 8'h12, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");

        // Reset mid-RUN aborts with no done pulse
        launch(8'h55, 8'h22, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 4) @(negedge clk);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        do_op("after_abort", 8'hA5, 8'h5A, 1'b0);

        // start held high: back-to-back with one IDLE cycle between
        c0 = cyc;
        launch(8'h33, 8'h44, 1'b0);
        @(negedge clk);
        a         = 8'hC8;
        b         = 8'h64;
        borrow_in = 1'b1;
        last_exp  = model(8'hC8, 8'h64, 1'b1, c0 + 2 * W + 3);
        sb.push_back(last_exp);
        while (cyc < c0 + W + 3) @(negedge clk);
        start = 1'b0;
        wait_done("b2b");

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                do_op("corner", corners[i], corners[j], 1'b0);
                do_op("corner_b", corners[i], corners[j], 1'b1);
            end
        end
        for (int k = 0; k < 150; k++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
